// File: rtl/sample_capture_pkg.sv
// rtl/sample_capture_pkg.sv - register map, bit positions and entry types for sample_capture_fifo
// Optional macro SAMPLE_TIMESTAMP_EN widens each entry with a 16-bit tick timestamp.
package sample_capture_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DROPS   = 2'd3;

  localparam int ST_EMPTY = 9;
  localparam int ST_FULL  = 10;
  localparam int ST_OVF   = 11;
  localparam int ST_UDF   = 12;

  localparam int CTL_EN     = 0;
  localparam int CTL_FLUSH  = 1;
  localparam int CTL_IRQ_EN = 2;
  localparam int CTL_CLR    = 3;

  typedef logic [15:0] sample_t;

`ifdef SAMPLE_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0] ts;
    sample_t     sample;
  } entry_t;
  localparam int ENTRY_W = 32;
`else
  localparam int ENTRY_W = 16;
`endif

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with wrap-bit pointers, flush and async active-low reset
// A pop on a full FIFO frees the slot for a same-cycle push; flush overrides push and pop.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sample_capture_fifo.sv
// rtl/sample_capture_fifo.sv - tick-triggered sample capture FIFO behind an Avalon-MM slave
// Optional macro SAMPLE_TIMESTAMP_EN stores a tick counter with each sample in DATA[31:16].
module sample_capture_fifo #(
  parameter int DEPTH         = 16,
  parameter int CAPTURE_DELAY = 2,
  parameter int DROP_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_tick,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);
  import sample_capture_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  logic                     tick_q, rise;
  logic [CAPTURE_DELAY-1:0] dly_q;
  logic [CAPTURE_DELAY:0]   dly_shift;
  logic                     enable_q, irq_en_q;
  logic                     ovf_q, ovf_d, udf_q, udf_d;
  logic [DROP_W-1:0]        drop_q, drop_d;
  logic [31:0]              rdata_q, rdata_d, status_w, data_word;
  logic                     push, pop, flush, clr, wr_ctl, drop_ev, udf_ev;
  logic                     full, empty;
  logic [AW:0]              level;
  logic [ENTRY_W-1:0]       fifo_wdata, fifo_rdata;
  logic                     unused_wd;

  assign rise      = sample_tick & ~tick_q;
  assign dly_shift = {dly_q, rise & enable_q};
  assign push      = dly_q[CAPTURE_DELAY-1] & enable_q;
  assign pop       = avs_read & (avs_address == ADDR_DATA);
  assign wr_ctl    = avs_write & (avs_address == ADDR_CONTROL);
  assign flush     = wr_ctl & avs_writedata[CTL_FLUSH];
  assign clr       = wr_ctl & avs_writedata[CTL_CLR];
  assign drop_ev   = push & full & ~(pop & ~empty) & ~flush;
  assign udf_ev    = pop & empty;
  assign unused_wd = &{1'b0, avs_writedata[31:4]};

`ifdef SAMPLE_TIMESTAMP_EN
  logic [15:0] ts_q;
  entry_t      wr_entry, rd_entry;

  // Counts every detected rise, even those that never reach the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ts_q <= '0;
    else if (rise) ts_q <= ts_q + 16'd1;
  end

  assign wr_entry   = '{ts: ts_q, sample: sample_in};
  assign fifo_wdata = wr_entry;
  assign rd_entry   = fifo_rdata;
  assign data_word  = {rd_entry.ts, rd_entry.sample};
`else
  assign fifo_wdata = sample_in;
  assign data_word  = {16'h0000, fifo_rdata};
`endif

  sample_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    status_w           = '0;
    status_w[8:0]      = 9'(level);
    status_w[ST_EMPTY] = empty;
    status_w[ST_FULL]  = full;
    status_w[ST_OVF]   = ovf_q;
    status_w[ST_UDF]   = udf_q;
  end

  // A concurrent event outranks clear, so an overflow during clear leaves drop_count=1.
  always_comb begin
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    drop_d = drop_q;
    if (clr) begin
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop_ev) begin
      ovf_d = 1'b1;
      if (!(&drop_d)) drop_d = drop_d + DROP_ONE;
    end
    if (udf_ev) udf_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:    rdata_d = empty ? 32'd0 : data_word;
        ADDR_STATUS:  rdata_d = status_w;
        ADDR_CONTROL: rdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
        default:      rdata_d = 32'(drop_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= 1'b0;
      dly_q    <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      drop_q   <= '0;
      rdata_q  <= '0;
    end else begin
      tick_q  <= sample_tick;
      dly_q   <= dly_shift[CAPTURE_DELAY-1:0];
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
      if (wr_ctl) begin
        enable_q <= avs_writedata[CTL_EN];
        irq_en_q <= avs_writedata[CTL_IRQ_EN];
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = ~empty & irq_en_q;

endmodule
